// File: rtl/ber_accumulator.sv
// Bit-error-rate accumulator: counts compared words, bits and bit errors from a
// PRBS checker over a word window or until stopped, tracking lock losses.
module ber_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 48,
    parameter int ERR_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] window,
    input  logic             lock,
    input  logic             valid,
    input  logic [WIDTH:0]   err_num,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic [15:0]      lock_loss_cnt,
    output logic             err_sat
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOCK,
        MEASURE,
        DONE
    } state_t;

    // The error sum must be wide enough for both the counter and a clamped
    // err_num, plus one carry bit to detect overflow.
    localparam int EW = ((ERR_W > WIDTH + 1) ? ERR_W : WIDTH + 1) + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t state, state_next;

    logic             clear, count, loss;
    logic [WIDTH:0]   err_clamp;
    logic [CNT_W:0]   word_sum, bit_sum;
    logic [EW-1:0]    err_sum;
    logic [16:0]      loss_sum;
    logic [CNT_W-1:0] word_inc, bit_inc;
    logic [ERR_W-1:0] err_inc;
    logic [15:0]      loss_inc;
    logic             count_sat, loss_sat;

    always_comb begin
        err_clamp = (err_num > (WIDTH+1)'(WIDTH)) ? (WIDTH+1)'(WIDTH) : err_num;
        word_sum  = {1'b0, word_cnt} + (CNT_W+1)'(1);
        bit_sum   = {1'b0, bit_cnt} + (CNT_W+1)'(WIDTH);
        err_sum   = EW'(err_cnt) + EW'(err_clamp);
        loss_sum  = {1'b0, lock_loss_cnt} + 17'd1;
        word_inc  = word_sum[CNT_W] ? '1 : word_sum[CNT_W-1:0];
        bit_inc   = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        err_inc   = (err_sum > EW'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
        loss_inc  = loss_sum[16] ? '1 : loss_sum[15:0];
        count_sat = (word_inc == '1) || (bit_inc == '1) || (err_inc == ERR_MAX);
        loss_sat  = (loss_inc == '1);
    end

    // Stop outranks lock loss, which outranks counting and window completion.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        count      = 1'b0;
        loss       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (stop)
                    state_next = DONE;
                else if (lock)
                    state_next = MEASURE;
            end
            MEASURE: begin
                if (stop) begin
                    state_next = DONE;
                end else if (!lock) begin
                    loss       = 1'b1;
                    state_next = WAIT_LOCK;
                end else if (valid) begin
                    count = 1'b1;
                    if ((window != '0) && (word_inc == window))
                        state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = WAIT_LOCK;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == WAIT_LOCK) || (state_next == MEASURE);
            done  <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt       <= '0;
            word_cnt      <= '0;
            err_cnt       <= '0;
            lock_loss_cnt <= '0;
            err_sat       <= 1'b0;
        end else if (clear) begin
            bit_cnt       <= '0;
            word_cnt      <= '0;
            err_cnt       <= '0;
            lock_loss_cnt <= '0;
            err_sat       <= 1'b0;
        end else if (count) begin
            bit_cnt  <= bit_inc;
            word_cnt <= word_inc;
            err_cnt  <= err_inc;
            err_sat  <= err_sat | count_sat;
        end else if (loss) begin
            lock_loss_cnt <= loss_inc;
            err_sat       <= err_sat | loss_sat;
        end
    end

endmodule
